// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide engine.
// Holds the operation encodings, the FSM state encodings, the controller
// alucontrol codes that map onto opE, and the divider iteration count.
package hilo_muldiv_pkg;

  // One quotient bit per cycle for a 32-bit datapath.
  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } md_state_t;

  // Controller alucontrol codes for the mul/div group. The low two bits
  // equal the md_op_t encoding, so the decode is a plain bit slice.
  localparam logic [7:0] ALU_MULT  = 8'h18;
  localparam logic [7:0] ALU_MULTU = 8'h19;
  localparam logic [7:0] ALU_DIV   = 8'h1a;
  localparam logic [7:0] ALU_DIVU  = 8'h1b;

  function automatic md_op_t alu_to_mdop(input logic [7:0] alu);
    return md_op_t'(alu[1:0]);
  endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// E/M-stage mul/div control bundle between the controller/hazard side (master)
// and the hilo_muldiv engine (slave).
// Master drives start/op/operands/flush and M-stage mthi/mtlo; slave returns
// forwarded HI/LO and the combinational stall request.
interface hilo_muldiv_if;
  logic        flushE;
  logic        startE;
  logic [1:0]  opE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic        is_mthiM;
  logic        is_mtloM;
  logic [31:0] wdataM;
  logic [31:0] hiE;
  logic [31:0] loE;
  logic        stall_mdE;

  modport master (
    output flushE, startE, opE, srcaE, srcbE, is_mthiM, is_mtloM, wdataM,
    input  hiE, loE, stall_mdE
  );

  modport slave (
    input  flushE, startE, opE, srcaE, srcbE, is_mthiM, is_mtloM, wdataM,
    output hiE, loE, stall_mdE
  );
endinterface

// File: rtl/hilo_muldiv_div_radix2.sv
// Radix-2 restoring divider on operand magnitudes with sign fix-up.
// Latency: start_i latches operands; done_o is high in the 32nd busy cycle,
// with quotient_o/remainder_o valid combinationally in that same cycle.
// Ports: clk, rst (async active-low), start_i, abort_i, signed_i,
// dividend_i, divisor_i in; done_o, quotient_o, remainder_o out.
module div_radix2
  import hilo_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  localparam int CW = $clog2(DIV_ITERS);

  logic          busy_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   rem_q;
  logic [31:0]   dvd_q;     // dividend bits shift out the top, quotient bits in the bottom
  logic [31:0]   dvs_q;
  logic [31:0]   raw_a_q;   // dividend as supplied, returned as HI on divide-by-zero
  logic          q_neg_q;
  logic          r_neg_q;
  logic          dz_q;

  logic [32:0]   rem_shift;
  logic [32:0]   diff;
  logic          qbit;
  logic [31:0]   rem_d;
  logic [31:0]   dvd_d;

  function automatic logic [31:0] mag(input logic [31:0] x, input logic s);
    return (s && x[31]) ? -x : x;
  endfunction

  // Trial subtraction on a 33-bit shifted remainder; keep it when non-negative.
  assign rem_shift = {rem_q, dvd_q[31]};
  assign diff      = rem_shift - {1'b0, dvs_q};
  assign qbit      = ~diff[32];
  assign rem_d     = qbit ? diff[31:0] : rem_shift[31:0];
  assign dvd_d     = {dvd_q[30:0], qbit};

  assign done_o      = busy_q && (cnt_q == CW'(DIV_ITERS - 1));
  assign quotient_o  = dz_q ? 32'hFFFF_FFFF : (q_neg_q ? -dvd_d : dvd_d);
  assign remainder_o = dz_q ? raw_a_q : (r_neg_q ? -rem_d : rem_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      raw_a_q <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
    end else if (abort_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q  <= 1'b1;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= mag(dividend_i, signed_i);
      dvs_q   <= mag(divisor_i, signed_i);
      raw_a_q <= dividend_i;
      q_neg_q <= signed_i && (dividend_i[31] ^ divisor_i[31]);
      r_neg_q <= signed_i && dividend_i[31];
      dz_q    <= (divisor_i == 32'd0);
    end else if (busy_q) begin
      rem_q <= rem_d;
      dvd_q <= dvd_d;
      if (done_o) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Execute-stage multiply/divide engine owning HI/LO, with M-stage forwarding.
// Latency: MULT/MULTU stall 2 cycles, DIV/DIVU stall 33 cycles; result visible in DONE.
// Backpressure: stall_mdE (combinational) freezes F/D/E; flushE aborts with no commit.
// Ports: clk, rst (async active-low), md (hilo_muldiv_if.slave).
module hilo_muldiv
  import hilo_muldiv_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  hilo_muldiv_if.slave   md
);

  md_state_t   state_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        mul_signed_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        start_go;
  logic        div_start;
  logic        div_done;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic        sa;
  logic        sb;
  logic [63:0] prod;

  assign start_go  = (state_q == IDLE) && md.startE && !md.flushE;
  assign div_start = start_go && md.opE[1];

  div_radix2 u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start),
    .abort_i     (md.flushE),
    .signed_i    (md.opE == MD_DIV),
    .dividend_i  (md.srcaE),
    .divisor_i   (md.srcbE),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  // Sign-extending both operands to 64 bits makes the low 64 bits of the
  // product correct for both signed and unsigned multiply.
  assign sa   = mul_signed_q && a_q[31];
  assign sb   = mul_signed_q && b_q[31];
  assign prod = {{32{sa}}, a_q} * {{32{sb}}, b_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      mul_signed_q <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      // M-stage writes first; a mul/div commit below overrides them since
      // the E-stage instruction is younger.
      if (md.is_mthiM) hi_q <= md.wdataM;
      if (md.is_mtloM) lo_q <= md.wdataM;

      unique case (state_q)
        IDLE: begin
          if (start_go) begin
            state_q      <= md.opE[1] ? DIV : MUL;
            a_q          <= md.srcaE;
            b_q          <= md.srcbE;
            mul_signed_q <= (md.opE == MD_MULT);
          end
        end
        MUL: begin
          if (md.flushE) begin
            state_q <= IDLE;
          end else begin
            hi_q    <= prod[63:32];
            lo_q    <= prod[31:0];
            state_q <= DONE;
          end
        end
        DIV: begin
          if (md.flushE) begin
            state_q <= IDLE;
          end else if (div_done) begin
            hi_q    <= div_rem;
            lo_q    <= div_quo;
            state_q <= DONE;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Gated by rst so a held startE cannot raise a stall while in reset.
  assign md.stall_mdE = rst && !md.flushE &&
                        (((state_q == IDLE) && md.startE) ||
                         (state_q == MUL) || (state_q == DIV));

  assign md.hiE = md.is_mthiM ? md.wdataM : hi_q;
  assign md.loE = md.is_mtloM ? md.wdataM : lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: scoreboard of expected HI/LO and stall
// lengths pushed at start, popped and compared when the stall drops.
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst;

  hilo_muldiv_if md_if ();

  hilo_muldiv dut (
    .clk (clk),
    .rst (rst),
    .md  (md_if)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
  } exp_t;

  exp_t scoreboard[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference results from native wide arithmetic.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint x;
    longint y;
    longint p;
    logic [63:0] pu;
    e.hi = '0;
    e.lo = '0;
    e.stalls = 33;
    case (op)
      2'b00: begin
        p = longint'($signed(a)) * longint'($signed(b));
        {e.hi, e.lo} = p;
        e.stalls = 2;
      end
      2'b01: begin
        pu = {32'd0, a} * {32'd0, b};
        {e.hi, e.lo} = pu;
        e.stalls = 2;
      end
      default: begin
        if (b == 32'd0) begin
          e.lo = 32'hFFFF_FFFF;
          e.hi = a;
        end else begin
          if (op == 2'b10) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
          end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
          end
          e.lo = 32'(x / y);
          e.hi = 32'(x % y);
        end
      end
    endcase
    return e;
  endfunction

  // Drive at posedge+2; outputs sampled at posedge+4.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   stalls;
    tick();
    md_if.startE = 1'b1;
    md_if.opE    = op;
    md_if.srcaE  = a;
    md_if.srcbE  = b;
    scoreboard.push_back(model(op, a, b));
    #2;
    stalls = 0;
    while (md_if.stall_mdE && stalls < 100) begin
      stalls++;
      if (stalls == 2) begin
        // Operands already captured; these must be ignored.
        md_if.srcaE = $urandom;
        md_if.srcbE = $urandom;
      end
      @(posedge clk);
      #4;
    end
    // DONE cycle: startE still held, stall must be low.
    e = scoreboard.pop_front();
    check_val({tag, "_stalls"}, 32'(stalls), 32'(e.stalls));
    check_val({tag, "_hi"}, md_if.hiE, e.hi);
    check_val({tag, "_lo"}, md_if.loE, e.lo);
    tick();
    md_if.startE = 1'b0;
  endtask

  initial begin
    exp_t e;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    rst            = 1'b0;
    md_if.flushE   = 1'b0;
    md_if.startE   = 1'b1;
    md_if.opE      = MD_DIV;
    md_if.srcaE    = 32'd5;
    md_if.srcbE    = 32'd3;
    md_if.is_mthiM = 1'b0;
    md_if.is_mtloM = 1'b0;
    md_if.wdataM   = '0;

    // Reset state, including a held startE.
    #3;
    check_val("rst_stall", {31'd0, md_if.stall_mdE}, 32'd0);
    check_val("rst_hi", md_if.hiE, 32'd0);
    check_val("rst_lo", md_if.loE, 32'd0);
    md_if.is_mthiM = 1'b1;
    md_if.wdataM   = 32'hAAAA_5555;
    #1;
    check_val("rst_fwd_hi", md_if.hiE, 32'hAAAA_5555);
    md_if.is_mthiM = 1'b0;
    md_if.startE   = 1'b0;
    tick();
    rst = 1'b1;
    #2;
    check_val("post_rst_hi", md_if.hiE, 32'd0);

    // Directed operations.
    run_op("mult_neg",  MD_MULT,  32'hFFFF_FFFE, 32'h0000_0003);
    run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_m7_2",  MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002);
    run_op("divu_100_7", MD_DIVU, 32'd100,       32'd7);
    run_op("divu_by0",  MD_DIVU,  32'd100,       32'd0);
    run_op("div_by0",   MD_DIV,   32'hFFFF_FF00, 32'd0);
    run_op("div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_7_m2",  MD_DIV,   32'd7,         32'hFFFF_FFFE);

    // mthi/mtlo forwarding and register write.
    tick();
    md_if.is_mthiM = 1'b1;
    md_if.wdataM   = 32'h1234_5678;
    #2;
    check_val("mthi_fwd", md_if.hiE, 32'h1234_5678);
    tick();
    md_if.is_mthiM = 1'b0;
    md_if.wdataM   = 32'h0;
    #2;
    check_val("mthi_reg", md_if.hiE, 32'h1234_5678);

    // Preload HI/LO, then flush a divide at DIV cycle 10.
    tick();
    md_if.is_mthiM = 1'b1;
    md_if.is_mtloM = 1'b1;
    md_if.wdataM   = 32'h1111_1111;
    tick();
    md_if.is_mthiM = 1'b0;
    md_if.wdataM   = 32'h2222_2222;
    tick();
    md_if.is_mtloM = 1'b0;
    #2;
    check_val("pre_hi", md_if.hiE, 32'h1111_1111);
    check_val("pre_lo", md_if.loE, 32'h2222_2222);
    md_if.startE = 1'b1;
    md_if.opE    = MD_DIV;
    md_if.srcaE  = 32'd1000;
    md_if.srcbE  = 32'd3;
    tick();
    repeat (10) tick();
    md_if.flushE = 1'b1;
    #2;
    check_val("flush_stall", {31'd0, md_if.stall_mdE}, 32'd0);
    tick();
    md_if.flushE = 1'b0;
    md_if.startE = 1'b0;
    #2;
    check_val("flush_idle_stall", {31'd0, md_if.stall_mdE}, 32'd0);
    repeat (35) tick();
    #2;
    check_val("flush_hi", md_if.hiE, 32'h1111_1111);
    check_val("flush_lo", md_if.loE, 32'h2222_2222);

    // flushE with startE in IDLE must not start anything.
    tick();
    md_if.startE = 1'b1;
    md_if.flushE = 1'b1;
    md_if.opE    = MD_MULT;
    #2;
    check_val("flush_start_stall", {31'd0, md_if.stall_mdE}, 32'd0);
    tick();
    md_if.startE = 1'b0;
    md_if.flushE = 1'b0;
    #2;
    check_val("flush_start_next", {31'd0, md_if.stall_mdE}, 32'd0);
    check_val("flush_start_lo", md_if.loE, 32'h2222_2222);

    run_op("mult_after_flush", MD_MULT, 32'd6, 32'hFFFF_FFF9);

    // mtlo coincident with a MULT commit: the product wins.
    tick();
    md_if.startE = 1'b1;
    md_if.opE    = MD_MULT;
    md_if.srcaE  = 32'h0001_2345;
    md_if.srcbE  = 32'hFFFF_FFFF;
    e = model(MD_MULT, 32'h0001_2345, 32'hFFFF_FFFF);
    tick();
    md_if.is_mtloM = 1'b1;
    md_if.wdataM   = 32'hDEAD_BEEF;
    #2;
    check_val("coinc_fwd_lo", md_if.loE, 32'hDEAD_BEEF);
    tick();
    md_if.is_mtloM = 1'b0;
    #2;
    check_val("coinc_stall", {31'd0, md_if.stall_mdE}, 32'd0);
    check_val("coinc_hi", md_if.hiE, e.hi);
    check_val("coinc_lo", md_if.loE, e.lo);
    tick();
    md_if.startE = 1'b0;

    // Randomised operations.
    for (int i = 0; i < 10; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 4 == 3) ? 32'($urandom_range(0, 5)) : $urandom;
      run_op($sformatf("rnd%0d", i), rop, ra, rb);
    end

    // Reset in the middle of a divide.
    tick();
    md_if.startE = 1'b1;
    md_if.opE    = MD_DIVU;
    md_if.srcaE  = 32'd100;
    md_if.srcbE  = 32'd7;
    repeat (6) tick();
    rst = 1'b0;
    #1;
    check_val("midrst_stall", {31'd0, md_if.stall_mdE}, 32'd0);
    check_val("midrst_hi", md_if.hiE, 32'd0);
    check_val("midrst_lo", md_if.loE, 32'd0);
    tick();
    md_if.startE = 1'b0;
    rst = 1'b1;
    #2;
    check_val("midrst_idle_stall", {31'd0, md_if.stall_mdE}, 32'd0);
    repeat (35) tick();
    #2;
    check_val("midrst_hi_late", md_if.hiE, 32'd0);
    check_val("midrst_lo_late", md_if.loE, 32'd0);

    run_op("mult_after_rst", MD_MULTU, 32'h0000_FFFF, 32'h0001_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
Execute-stage multiply/divide engine and HI/LO register file for the myCPU pipeline. It consumes the multiply/divide and HI/LO control that the controller produces: E-stage start/op, M-stage mthi/mtlo writes, and E-stage mfhi/mflo reads. It returns a stall request to the hazard logic that freezes F/D/E while a multi-cycle operation runs. HI/LO are owned here; results commit only on normal completion.

Parameters:
DIV_ITERS, 32, radix-2 quotient bits produced (one per cycle); fixed for a 32-bit datapath.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
flushE  in  1  kill the E-stage instruction; abort any operation in progress
startE  in  1  a mult/div instruction is valid in E
opE  in  2  operation: MD_MULT, MD_MULTU, MD_DIV or MD_DIVU
srcaE  in  32  rs operand, already forwarded
srcbE  in  32  rt operand, already forwarded
is_mthiM  in  1  M-stage mthi write
is_mtloM  in  1  M-stage mtlo write
wdataM  in  32  mthi/mtlo data
hiE  out  32  HI value for mfhi in E, with M-stage forwarding
loE  out  32  LO value for mflo in E, with M-stage forwarding
stall_mdE  out  1  stall request to the hazard unit; combinational

Behaviour:
- Reset (rst=0, async): hi_r=0, lo_r=0, state=IDLE, iteration counter=0. Outputs during reset: stall_mdE=0, hiE=0, loE=0 unless M-stage forwarding is active.
- States:
  - IDLE: startE=1 and flushE=0 → latch opE and operands, assert stall_mdE, go to MUL (MULT/MULTU) or DIV (DIV/DIVU).
  - MUL: stall_mdE=1. Form the 64-bit product: signed for MULT, unsigned for MULTU. Write {hi_r,lo_r} at the clock edge. Go to DONE.
  - DIV: stall_mdE=1. Restoring division on magnitudes with a 33-bit partial remainder, one quotient bit per cycle, counter 0..31. At count 31, apply signs and write lo_r=quotient, hi_r=remainder at the edge. Go to DONE.
  - DONE: stall_mdE=0. startE is ignored because the same instruction is still in E. Go to IDLE.
- Latency:
  - MULT/MULTU: stall_mdE high for exactly 2 cycles (IDLE-start, MUL). Result is visible on hiE/loE in DONE.
  - DIV/DIVU: stall_mdE high for exactly 33 cycles (IDLE-start plus 32 DIV cycles).
- Signed divide rules:
  - Quotient is negative iff the operand signs differ.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero (either signedness), no trap:
  - Result: LO=0xFFFFFFFF, HI=dividend as supplied (srcaE).
  - The full 32-cycle latency is still taken.
- flushE=1 in any state → next state IDLE, no HI/LO commit, stall_mdE=0 in that same cycle. If flushE and startE are both high in IDLE, no start occurs.
- mthi/mtlo: hi_r/lo_r take wdataM at the clock edge when is_mthiM/is_mtloM is 1.
- Coincident writes: if a mul/div commit lands on the same edge as an M-stage mthi/mtlo, the mul/div result wins, because the E-stage instruction is the younger one.
- Read forwarding:
  - hiE = is_mthiM ? wdataM : hi_r
  - loE = is_mtloM ? wdataM : lo_r
- Operands are captured only at start. Changes on srcaE/srcbE during stall are ignored.

Decomposition:
- Shared defines header holds:
  - opcode constants MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11
  - state encodings IDLE/MUL/DIV/DONE
  - the mul/div alucontrol codes, so the controller decode maps onto opE
- One sub-module, div_radix2: owns the magnitude conversion, the iteration counter, the partial remainder and sign fix-up. Handshake: start/abort/done. Outputs: quotient and remainder.
- The top level keeps the FSM, the multiplier, HI/LO and forwarding.

Test Plan:
1. MULT srca=0xFFFFFFFE, srcb=0x00000003 → stall_mdE high 2 cycles; then hiE=0xFFFFFFFF, loE=0xFFFFFFFA.
2. MULTU srca=0xFFFFFFFF, srcb=0xFFFFFFFF → hiE=0xFFFFFFFE, loE=0x00000001.
3. DIV srca=0xFFFFFFF9 (-7), srcb=0x00000002 → stall_mdE high exactly 33 cycles; then loE=0xFFFFFFFD, hiE=0xFFFFFFFF. Repeat with DIVU 100/7 → loE=14, hiE=2.
4. DIVU srca=100, srcb=0 → loE=0xFFFFFFFF, hiE=0x00000064 after 33 stall cycles.
5. Preload HI=0x11111111, LO=0x22222222; start DIV; assert flushE on DIV cycle 10 → stall_mdE=0 that cycle, IDLE next cycle, HI/LO unchanged. Then assert rst low mid-DIV → HI=LO=0, IDLE, stall_mdE=0.
6. is_mthiM=1, wdataM=0x12345678 → hiE=0x12345678 in the same cycle and hi_r=0x12345678 after the edge. Also drive an mtlo on the same edge as a MULT commit → LO holds the product.
